// File: rtl/floor_call_scheduler.sv
// Floor call capture and one-at-a-time issue to the elevator scheduling stage.
// Define FLOOR_CALL_DEBOUNCE_EN to insert the per-floor debounce filter after the synchronizer.
module floor_call_scheduler #(
  parameter int FLOORS          = 8,
  parameter int FLOOR_W         = 3,
  parameter int WEIGHT_W        = 11,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [FLOORS-1:0]   call_btn,
  input  logic [WEIGHT_W-1:0] weight,
  input  logic                complete,
  input  logic [FLOOR_W-1:0]  out_floor,
  output logic [FLOOR_W-1:0]  req_floor,
  output logic [WEIGHT_W-1:0] req_weight,
  output logic                req_valid,
  input  logic                req_ready,
  output logic [FLOORS-1:0]   pending,
  output logic                busy
);

  // state   | meaning
  // S_IDLE  | waiting for an unissued pending call
  // S_OFFER | req_valid high, waiting for req_ready or an arrival on the offered floor
  // S_GAP   | post-transfer quiet time, req_floor held
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  if (FLOORS != (1 << FLOOR_W) || DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15 ||
      GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_params
    $error("floor_call_scheduler: illegal parameter combination");
  end

  localparam logic [FLOORS-1:0] FLOOR0_KEEP = {{(FLOORS-1){1'b1}}, 1'b0};

  state_t             state;
  logic [FLOORS-1:0]  sync1, sync2, deb, deb_q;
  logic [FLOORS-1:0]  issued, cand, clr_mask, issue_mask;
  logic [FLOOR_W-1:0] rr_ptr, pick, idx, next_ptr;
  logic               found, arrive_req;
  logic [3:0]         gap_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb_q <= '0;
    end else begin
      sync1 <= call_btn;
      sync2 <= sync1;
      deb_q <= deb;
    end
  end

`ifdef FLOOR_CALL_DEBOUNCE_EN
  logic [3:0] deb_cnt [FLOORS];

  // A level change is accepted only after it has disagreed with deb for DEBOUNCE_CYCLES+1 samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= '0;
      for (int f = 0; f < FLOORS; f++) deb_cnt[f] <= '0;
    end else begin
      for (int f = 0; f < FLOORS; f++) begin
        if (sync2[f] == deb[f]) begin
          deb_cnt[f] <= '0;
        end else if (deb_cnt[f] == 4'(DEBOUNCE_CYCLES)) begin
          deb[f]     <= sync2[f];
          deb_cnt[f] <= '0;
        end else begin
          deb_cnt[f] <= deb_cnt[f] + 4'd1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) deb <= '0;
    else        deb <= sync2;
  end
`endif

  always_comb begin
    clr_mask = '0;
    if (complete) clr_mask[out_floor] = 1'b1;
  end

  // Clear beats a same-cycle set; floor 0 never becomes pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending | (deb & ~deb_q)) & ~clr_mask & FLOOR0_KEEP;
  end

  assign cand       = pending & ~issued;
  assign arrive_req = complete && (out_floor == req_floor);

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      idx = rr_ptr + FLOOR_W'(i);
      if (!found && cand[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    next_ptr = req_floor + FLOOR_W'(1);
    if (next_ptr == '0) next_ptr = FLOOR_W'(1);
  end

  always_comb begin
    issue_mask = '0;
    if (state == S_OFFER && req_ready && !arrive_req) issue_mask[req_floor] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      req_floor  <= '0;
      req_weight <= '0;
      req_valid  <= 1'b0;
      busy       <= 1'b0;
      issued     <= '0;
      rr_ptr     <= FLOOR_W'(1);
      gap_cnt    <= '0;
    end else begin
      issued <= (issued | issue_mask) & ~clr_mask;
      case (state)
        S_IDLE: begin
          if (found) begin
            req_floor  <= pick;
            req_weight <= weight;
            req_valid  <= 1'b1;
            busy       <= 1'b1;
            state      <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (arrive_req) begin
            req_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else if (req_ready) begin
            req_valid <= 1'b0;
            rr_ptr    <= next_ptr;
            gap_cnt   <= 4'(GAP_CYCLES - 1);
            state     <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          req_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_floor_call_scheduler.sv
// Bench for floor_call_scheduler: directed scenarios with literal expectations plus a
// randomized run, all cycles checked against a behavioural model of the call rules.
module tb_floor_call_scheduler;
  localparam int FLOORS   = 8;
  localparam int FLOOR_W  = 3;
  localparam int WEIGHT_W = 11;
  localparam int DEB      = 4;
  localparam int GAP      = 2;
  localparam int HIST     = 20;
`ifdef FLOOR_CALL_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
  localparam int LAT    = 2 + DEB + 1;
`else
  localparam bit DEB_ON = 1'b0;
  localparam int LAT    = 3;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [FLOORS-1:0]   call_btn = '0;
  logic [WEIGHT_W-1:0] weight = '0;
  logic                complete = 1'b0;
  logic [FLOOR_W-1:0]  out_floor = '0;
  logic                req_ready = 1'b0;
  logic [FLOOR_W-1:0]  req_floor;
  logic [WEIGHT_W-1:0] req_weight;
  logic                req_valid;
  logic [FLOORS-1:0]   pending;
  logic                busy;

  int n_checks = 0;
  int n_fail   = 0;

  floor_call_scheduler #(
    .FLOORS(FLOORS), .FLOOR_W(FLOOR_W), .WEIGHT_W(WEIGHT_W),
    .DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .call_btn(call_btn), .weight(weight),
    .complete(complete), .out_floor(out_floor), .req_floor(req_floor),
    .req_weight(req_weight), .req_valid(req_valid), .req_ready(req_ready),
    .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- behavioural model ----------------
  logic [FLOORS-1:0] m_pending, m_issued, m_deb, m_deb_q, m_clr, m_cand, m_rise;
  logic [FLOORS-1:0] hist[$];
  bit                m_offer, m_all_diff;
  int                m_floor, m_weight, m_gap, m_rr, m_f;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending = '0; m_issued = '0; m_deb = '0; m_deb_q = '0;
      m_offer = 1'b0; m_floor = 0; m_weight = 0; m_gap = 0; m_rr = 1;
      hist = {};
      for (int i = 0; i < HIST; i++) hist.push_back('0);
    end else begin
      m_clr = '0;
      if (complete) m_clr[out_floor] = 1'b1;
      m_cand = m_pending & ~m_issued;
      m_rise = m_deb & ~m_deb_q;
      if (m_offer) begin
        if (complete && int'(out_floor) == m_floor) begin
          m_offer = 1'b0;
        end else if (req_ready) begin
          m_offer = 1'b0;
          m_issued[m_floor] = 1'b1;
          m_rr = (m_floor + 1) % FLOORS;
          if (m_rr == 0) m_rr = 1;
          m_gap = GAP;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (m_cand != '0) begin
        for (int i = 0; i < FLOORS; i++) begin
          m_f = (m_rr + i) % FLOORS;
          if (m_cand[m_f]) begin
            m_floor = m_f;
            break;
          end
        end
        m_weight = int'(weight);
        m_offer  = 1'b1;
      end
      m_issued  = m_issued & ~m_clr;
      m_pending = (m_pending | m_rise) & ~m_clr;
      m_pending[0] = 1'b0;
      hist.push_front(call_btn);
      void'(hist.pop_back());
      m_deb_q = m_deb;
`ifdef FLOOR_CALL_DEBOUNCE_EN
      for (int f = 0; f < FLOORS; f++) begin
        m_all_diff = 1'b1;
        for (int j = 2; j <= 2 + DEB; j++)
          if (hist[j][f] == m_deb[f]) m_all_diff = 1'b0;
        if (m_all_diff) m_deb[f] = ~m_deb[f];
      end
`else
      m_deb = hist[2];
`endif
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp_valid",   32'(req_valid),  32'(m_offer));
      check("cmp_floor",   32'(req_floor),  32'(m_floor));
      check("cmp_weight",  32'(req_weight), 32'(m_weight));
      check("cmp_pending", 32'(pending),    32'(m_pending));
      check("cmp_busy",    32'(busy),       32'(m_offer || m_gap > 0));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_reset();
    call_btn = '0; complete = 1'b0; req_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic press_wait(input logic [FLOORS-1:0] mask, input int hold, input int budget,
                            output bit found);
    found = 1'b0;
    call_btn = mask;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (i == hold - 1) call_btn = '0;
      if (req_valid) begin
        found = 1'b1;
        break;
      end
    end
    call_btn = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   found;
    int   vcount, n_xfer, changes, last, min_sp;
    int   order[3];
    logic [FLOOR_W-1:0] prev;
    logic [FLOORS-1:0]  p_or;

    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("rst_floor",   32'(req_floor),  32'd0);
    check("rst_weight",  32'(req_weight), 32'd0);
    check("rst_valid",   32'(req_valid),  32'd0);
    check("rst_pending", 32'(pending),    32'd0);
    check("rst_busy",    32'(busy),       32'd0);

    // single press on floor 5
    do_reset();
    req_ready = 1'b1;
    weight = 11'd350;
    call_btn = 8'h20;
    tick(LAT);
    check("t1_pend_early", 32'(pending), 32'h00);
    tick(1);
    check("t1_pend_set", 32'(pending), 32'h20);
    tick(1);
    check("t1_valid",  32'(req_valid),  32'd1);
    check("t1_floor",  32'(req_floor),  32'd5);
    check("t1_weight", 32'(req_weight), 32'd350);
    weight = 11'd999;
    tick(1);
    check("t1_drop", 32'(req_valid), 32'd0);
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      if (LAT + 4 + i >= 10) call_btn = '0;
      tick(1);
      vcount += int'(req_valid);
    end
    call_btn = '0;
    check("t1_one_issue", 32'(vcount), 32'd0);
    check("t1_weight_held", 32'(req_weight), 32'd350);

    // two-cycle glitch on floor 3
    do_reset();
    req_ready = 1'b1;
    call_btn = 8'h08;
    tick(2);
    call_btn = '0;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      vcount += int'(req_valid);
    end
    check("t2_glitch_pend",  32'(pending), DEB_ON ? 32'h00 : 32'h08);
    check("t2_glitch_valid", 32'(vcount),  DEB_ON ? 32'd0  : 32'd1);

    // simultaneous presses 2, 6, 4
    do_reset();
    req_ready = 1'b1;
    call_btn = 8'b0101_0100;
    n_xfer = 0; changes = 0; last = -100; min_sp = 1000;
    prev = req_floor;
    order[0] = 0; order[1] = 0; order[2] = 0;
    for (int c = 0; c < 60; c++) begin
      if (c == 12) call_btn = '0;
      tick(1);
      if (req_floor != prev) changes++;
      prev = req_floor;
      if (req_valid && req_ready) begin
        if (n_xfer < 3) order[n_xfer] = int'(req_floor);
        if (n_xfer > 0 && (c - last) < min_sp) min_sp = c - last;
        last = c;
        n_xfer++;
      end
    end
    call_btn = '0;
    check("t3_xfers",   32'(n_xfer),   32'd3);
    check("t3_order0",  32'(order[0]), 32'd2);
    check("t3_order1",  32'(order[1]), 32'd4);
    check("t3_order2",  32'(order[2]), 32'd6);
    check("t3_spacing", 32'(min_sp >= GAP + 2), 32'd1);
    check("t3_changes", 32'(changes),  32'd3);

    // arrival while offer stalled on floor 6
    do_reset();
    req_ready = 1'b0;
    press_wait(8'h40, 8, 30, found);
    check("t4_offer", 32'(found), 32'd1);
    tick(3);
    check("t4_held_valid", 32'(req_valid), 32'd1);
    check("t4_held_floor", 32'(req_floor), 32'd6);
    complete = 1'b1;
    out_floor = 3'd6;
    tick(1);
    complete = 1'b0;
    check("t4_valid_drop", 32'(req_valid),  32'd0);
    check("t4_pend_clear", 32'(pending[6]), 32'd0);
    req_ready = 1'b1;
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      vcount += int'(req_valid);
    end
    check("t4_no_reoffer", 32'(vcount), 32'd0);

    // floor 7 re-press before and after arrival
    do_reset();
    req_ready = 1'b1;
    press_wait(8'h80, 8, 30, found);
    check("t5_first", 32'(found), 32'd1);
    check("t5_first_floor", 32'(req_floor), 32'd7);
    tick(6);
    call_btn = 8'h80;
    vcount = 0;
    for (int i = 0; i < 25; i++) begin
      if (i == 8) call_btn = '0;
      tick(1);
      vcount += int'(req_valid);
    end
    check("t5_no_dup", 32'(vcount), 32'd0);
    check("t5_pend_kept", 32'(pending), 32'h80);
    complete = 1'b1;
    out_floor = 3'd7;
    tick(1);
    complete = 1'b0;
    check("t5_served", 32'(pending), 32'h00);
    press_wait(8'h80, 8, 30, found);
    check("t5_rearm", 32'(found), 32'd1);
    check("t5_rearm_floor", 32'(req_floor), 32'd7);
    tick(3);

    // floor 0 press is ignored
    do_reset();
    req_ready = 1'b1;
    call_btn = 8'h01;
    vcount = 0;
    p_or = '0;
    for (int i = 0; i < 15; i++) begin
      if (i == 10) call_btn = '0;
      tick(1);
      vcount += int'(req_valid);
      p_or |= pending;
    end
    check("t6_floor0_pend",  32'(p_or),   32'd0);
    check("t6_floor0_valid", 32'(vcount), 32'd0);

    // asynchronous reset during an offer
    do_reset();
    req_ready = 1'b0;
    press_wait(8'h08, 8, 30, found);
    check("t6_offer", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_ar_valid",   32'(req_valid),  32'd0);
    check("t6_ar_floor",   32'(req_floor),  32'd0);
    check("t6_ar_weight",  32'(req_weight), 32'd0);
    check("t6_ar_pending", 32'(pending),    32'd0);
    check("t6_ar_busy",    32'(busy),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      vcount += int'(req_valid);
    end
    check("t6_lost_pend",  32'(pending), 32'd0);
    check("t6_lost_valid", 32'(vcount),  32'd0);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int f = 0; f < FLOORS; f++)
        if ($urandom_range(0, 15) == 0) call_btn[f] = ~call_btn[f];
      req_ready = ($urandom_range(0, 3) != 0);
      weight = WEIGHT_W'($urandom);
      complete = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 0) out_floor = req_floor;
      else out_floor = FLOOR_W'($urandom_range(0, FLOORS - 1));
      tick(1);
    end
    call_btn = '0;
    complete = 1'b0;
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/floor_call_scheduler.md
# floor_call_scheduler

Upstream of the elevator scheduling algorithms. Captures raw floor call buttons, synchronizes and debounces them, and holds one pending-call bit per floor. Issues outstanding calls one at a time on `req_floor`/`req_weight` with a valid/ready handshake. Retires each call when the car reports arrival at that floor through `complete` and `out_floor`.

## Interface

Parameters:
- `FLOORS`, default 8: number of floors. Floor 0 is reserved as "no request" and is never issued.
- `FLOOR_W`, default 3: floor index width; must satisfy 2^FLOOR_W = FLOORS.
- `WEIGHT_W`, default 11: load-cell weight width.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required to accept a button level change; range 1..15.
- `GAP_CYCLES`, default 2: idle cycles after each accepted issue, with `req_floor` held; range 1..15.

Ports (reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `call_btn`  in  FLOORS  raw asynchronous button levels, 1 = pressed. Bit 0 is ignored.
- `weight`  in  WEIGHT_W  current cabin load, sampled at issue.
- `complete`  in  1  arrival strobe from the algorithm stage.
- `out_floor`  in  FLOOR_W  current car floor from the algorithm stage.
- `req_floor`  out  FLOOR_W  floor being offered or last issued.
- `req_weight`  out  WEIGHT_W  weight sampled with `req_floor`.
- `req_valid`  out  1  offer valid.
- `req_ready`  in  1  downstream accepts the offer.
- `pending`  out  FLOORS  outstanding calls, for hall lanterns.
- `busy`  out  1  FSM is not in IDLE.

## Operation

Input path:
- Each `call_btn[f]` passes through a 2-flop synchronizer, then the debounce filter.
- A rising edge of the debounced level sets `pending[f]`.
- `pending[0]` is constant 0.

Clear rule:
- When `complete`=1, `pending[out_floor]` and `issued[out_floor]` are cleared.
- If a set and a clear hit the same floor in the same cycle, the clear wins.
- A press for a floor that is already pending has no effect.

Candidate selection:
- `cand = pending & ~issued`.
- Round-robin pointer `rr_ptr` resets to 1. It wraps from FLOORS-1 to 1 and skips 0.
- The pick is the first set bit of `cand` at or above `rr_ptr`, wrapping around.

FSM:
- IDLE: if `cand` is nonzero, load `req_floor` with the pick and `req_weight` with `weight`, then go to OFFER.
- OFFER: `req_valid`=1.
  - If `req_floor` is cleared this cycle (arrival), drop to IDLE with no issue.
  - Otherwise, when `req_ready`=1: set `issued[req_floor]`, set `rr_ptr` to `req_floor`+1 (wrapped), and go to GAP.
- GAP: `req_valid`=0 and `req_floor` held for GAP_CYCLES cycles, then IDLE.

Invariants:
- `req_floor` and `req_weight` change only on the IDLE→OFFER transition, so the level-sensitive downstream capture sees exactly one change per issue.
- A call that is issued but not yet served is not re-issued.
- A new press after a call is served re-arms that floor.

## Timing

- Reset values: `req_floor`=0, `req_weight`=0, `req_valid`=0, `pending`=0, `busy`=0, `issued`=0, `rr_ptr`=1, FSM=IDLE, synchronizer and debounce state all 0.
- Reset asserted mid-OFFER drops `req_valid` asynchronously; all calls are lost.
- Press latency: `call_btn` held high from edge k sets `pending` at edge k+2+DEBOUNCE_CYCLES+1.
- Issue latency: `cand` nonzero in IDLE at edge n gives `req_valid`=1 after edge n+1.
- Handshake: transfer happens on an edge where `req_valid`=1 and `req_ready`=1. `req_valid` deasserts the following cycle.
- Back-to-back issue spacing is at least GAP_CYCLES+2 cycles.
- `req_valid` is never withdrawn without a transfer, except by the arrival-clear rule or reset.
- `busy` = (state != IDLE), registered.

## Configuration

- `FLOOR_CALL_DEBOUNCE_EN` defined: debounce filter as above. A counter per floor counts consecutive cycles where the synchronized level differs from the debounced level. The debounced level updates when the count reaches DEBOUNCE_CYCLES; the counter resets on any agreement.
- `FLOOR_CALL_DEBOUNCE_EN` undefined: no filter. The debounced level equals the synchronized level, press latency is 3 cycles, and the DEBOUNCE_CYCLES parameter is unused.

## Test plan

- Reset, then press floor 5 for 10 cycles with `req_ready`=1 and `weight`=350 → `pending`=8'b0010_0000 at cycle 7; `req_valid` high for one cycle with `req_floor`=5, `req_weight`=350.
- A 2-cycle glitch on floor 3 (with debounce enabled) → `pending` stays 0 and `req_valid` never asserts.
- Press floors 2, 6 and 4 together with `req_ready`=1 → issue order 2, 4, 6, each transfer separated by at least 4 cycles; `req_floor` changes exactly three times.
- Hold `req_ready`=0 while offering floor 6, then pulse `complete` with `out_floor`=6 → `req_valid` drops, `pending[6]` clears, floor 6 is never transferred.
- Issue floor 7, then press floor 7 again before arrival → no second issue. After `complete` with `out_floor`=7, a new press re-issues floor 7.
- Press floor 0, and separately assert `rst_n`=0 during OFFER → floor 0 is never pending; reset forces all outputs to their reset values immediately.
